uart_tx_param: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_param_if.sv | 35 +++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_tx_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity constants and frame-length helper for the UART blocks.
// Rev 1.0
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_CLEANUP = 3'd5,
        ST_BREAK   = 3'd6
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int frame_bits(input int data_bits, input int parity_mode, input int stop_bits);
        return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready word input and serial-side status of the UART transmitter.
// Rev 1.0. i_Tx_Break exists only when UART_TX_BREAK_EN is defined.
`default_nettype none

interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Byte;
`ifdef UART_TX_BREAK_EN
    logic                 i_Tx_Break;
`endif
    logic                 o_Tx_Ready;
    logic                 o_Tx_Active;
    logic                 o_Tx_Serial;
    logic                 o_Tx_Done;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
`ifdef UART_TX_BREAK_EN
        output i_Tx_Break,
`endif
        input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
`ifdef UART_TX_BREAK_EN
        input  i_Tx_Break,
`endif
        output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );
endinterface

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: CLKS_PER_BIT period counter with restart and a one-cycle bit_end strobe.
// Rev 1.0
`default_nettype none

module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic restart_i,
    input  wire logic en_i,
    output logic      bit_end_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end_o = en_i && (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised LSB-first UART transmitter with valid/ready input.
// Rev 1.0. Optional line-break generation enabled by UART_TX_BREAK_EN.
`default_nettype none

module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  wire logic        i_Clock,
    input  wire logic        i_Reset,
    uart_tx_param_if.slave   bus
);
    // Index covers both data and stop bits; always fewer than the frame length.
    localparam int IDX_W = $clog2(frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS));

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_ODD && PARITY_MODE != PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 parity_q;
    logic                 serial_q;
    logic                 ready_q;
    logic                 active_q;
    logic                 done_q;

    logic w_break;
    logic w_accept;
    logic w_timing;
    logic w_bit_end;

`ifdef UART_TX_BREAK_EN
    assign w_break = bus.i_Tx_Break;
`else
    assign w_break = 1'b0;
`endif

    assign w_accept = (state_q == ST_IDLE) && ready_q && bus.i_Tx_DV && !w_break;
    assign w_timing = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .restart_i (w_accept),
        .en_i      (w_timing),
        .bit_end_o (w_bit_end)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
                    if (w_break) begin
                        state_q  <= ST_BREAK;
                        serial_q <= 1'b0;
                        ready_q  <= 1'b0;
                        active_q <= 1'b1;
                    end else
`endif
                    if (w_accept) begin
                        state_q  <= ST_START;
                        shift_q  <= bus.i_Tx_Byte;
                        parity_q <= (PARITY_MODE == PARITY_ODD) ? ~^bus.i_Tx_Byte : ^bus.i_Tx_Byte;
                        idx_q    <= '0;
                        serial_q <= 1'b0;
                        ready_q  <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        state_q  <= ST_DATA;
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                            idx_q <= '0;
                            if (PARITY_MODE != PARITY_NONE) begin
                                state_q  <= ST_PARITY;
                                serial_q <= parity_q;
                            end else begin
                                state_q  <= ST_STOP;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        state_q  <= ST_STOP;
                        serial_q <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                            state_q  <= ST_CLEANUP;
                            idx_q    <= '0;
                            done_q   <= 1'b1;
                            active_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_CLEANUP: begin
                    state_q  <= ST_IDLE;
                    serial_q <= 1'b1;
                    done_q   <= 1'b0;
                    ready_q  <= 1'b1;
                end
`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    if (!w_break) begin
                        state_q  <= ST_CLEANUP;
                        serial_q <= 1'b1;
                        done_q   <= 1'b1;
                        active_q <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q  <= ST_IDLE;
                    idx_q    <= '0;
                    serial_q <= 1'b1;
                    ready_q  <= 1'b1;
                    active_q <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Tx_Serial = serial_q;
    assign bus.o_Tx_Ready  = ready_q;
    assign bus.o_Tx_Active = active_q;
    assign bus.o_Tx_Done   = done_q;
endmodule

`default_nettype wire
